// File: rtl/act_mac_seq.sv
// act_mac_seq: serial multiply-accumulate controller for one LSTM gate neuron.
// A single multiplier walks the N = NUM+NUM_LSTM input/weight pairs, adds the
// bias, saturates to WIDTH and hands the sum to a shared activation unit over
// a req/ack handshake. Weight/bias writes that arrive while busy are parked in
// a one-deep pending buffer and committed when the operation finishes.
module act_mac_seq #(
  parameter int NUM      = 68,
  parameter int NUM_LSTM = 8,
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [(NUM+NUM_LSTM)*WIDTH-1:0]   i_k,
  input  logic                              i_wr,
  input  logic [(NUM+NUM_LSTM)*WIDTH-1:0]   i_w,
  input  logic [WIDTH-1:0]                  i_b,
  output logic                              o_busy,
  output logic                              o_act_req,
  output logic [WIDTH-1:0]                  o_act_x,
  input  logic                              i_act_ack,
  input  logic [WIDTH-1:0]                  i_act_y,
  output logic [WIDTH-1:0]                  o_a,
  output logic                              o_valid,
  output logic [(NUM+NUM_LSTM)*WIDTH-1:0]   o_w,
  output logic [WIDTH-1:0]                  o_b
);

  localparam int N    = NUM + NUM_LSTM;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_BIAS,
    S_ACT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [N*WIDTH-1:0]        w_reg;
  logic [WIDTH-1:0]          b_reg;
  logic [N*WIDTH-1:0]        pend_w;
  logic [WIDTH-1:0]          pend_b;
  logic                      pend_valid;
  logic [N*WIDTH-1:0]        k_buf;
  logic [IDXW-1:0]           idx;
  logic signed [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]          act_x;
  logic [WIDTH-1:0]          a_reg;

  logic [WIDTH-1:0]          k_cur;
  logic [WIDTH-1:0]          w_cur;
  logic signed [2*WIDTH-1:0] k_ext;
  logic signed [2*WIDTH-1:0] w_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] term;
  logic signed [2*WIDTH-1:0] sum;
  logic [WIDTH-1:0]          sat_x;
  logic                      sum_fits;

  // The input vector shifts down one word per MAC cycle; weights are selected by index
  assign k_cur = k_buf[WIDTH-1:0];
  assign w_cur = w_reg[idx*WIDTH +: WIDTH];
  assign k_ext = {{WIDTH{k_cur[WIDTH-1]}}, k_cur};
  assign w_ext = {{WIDTH{w_cur[WIDTH-1]}}, w_cur};
  assign prod  = k_ext * w_ext;
  assign term  = prod >>> FRAC;
  assign sum   = acc + {{WIDTH{b_reg[WIDTH-1]}}, b_reg};

  // The sum fits in WIDTH when every bit from the WIDTH-1 sign position upward agrees
  assign sum_fits = (&sum[2*WIDTH-1:WIDTH-1]) | ~(|sum[2*WIDTH-1:WIDTH-1]);

  // Clamp the biased sum to the most positive / most negative WIDTH-bit value
  always_comb begin
    sat_x = sum[WIDTH-1:0];
    if (!sum_fits) begin
      if (sum[2*WIDTH-1]) begin
        sat_x = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        sat_x = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a fixed walk through the pipeline, waiting only on the ack
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (i_start) state_next = S_LOAD;
      S_LOAD: state_next = S_MAC;
      S_MAC:  if (idx == IDXW'(N-1)) state_next = S_BIAS;
      S_BIAS: state_next = S_ACT;
      S_ACT:  if (i_act_ack) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Weight/bias register: direct writes when idle, parked writes committed on leaving DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_reg      <= '0;
      b_reg      <= '0;
      pend_w     <= '0;
      pend_b     <= '0;
      pend_valid <= 1'b0;
    end else if (state == S_IDLE) begin
      if (i_wr) begin
        w_reg <= i_w;
        b_reg <= i_b;
      end
    end else if (state == S_DONE) begin
      if (i_wr) begin
        w_reg <= i_w;
        b_reg <= i_b;
      end else if (pend_valid) begin
        w_reg <= pend_w;
        b_reg <= pend_b;
      end
      pend_valid <= 1'b0;
    end else if (i_wr) begin
      pend_w     <= i_w;
      pend_b     <= i_b;
      pend_valid <= 1'b1;
    end
  end

  // Datapath: capture inputs, accumulate one product per cycle, then bias and saturate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_buf <= '0;
      acc   <= '0;
      idx   <= '0;
      act_x <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          k_buf <= i_k;
          acc   <= '0;
          idx   <= '0;
        end
        S_MAC: begin
          acc   <= acc + term;
          k_buf <= k_buf >> WIDTH;
          idx   <= idx + IDXW'(1);
        end
        S_BIAS: begin
          act_x <= sat_x;
        end
        default: begin
        end
      endcase
    end
  end

  // Activation result is captured on the edge that sees the ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
    end else if (state == S_ACT && i_act_ack) begin
      a_reg <= i_act_y;
    end
  end

  assign o_busy    = (state != S_IDLE);
  assign o_act_req = (state == S_ACT);
  assign o_valid   = (state == S_DONE);
  assign o_act_x   = act_x;
  assign o_a       = a_reg;
  assign o_w       = w_reg;
  assign o_b       = b_reg;

endmodule

// File: tb/tb_act_mac_seq.sv
// Testbench for act_mac_seq with NUM=2, NUM_LSTM=1 (N=3), Q8.24 words.
// Fixed vectors, hand-built corner sequences and randomized operations are
// checked against an arithmetic reference model of the neuron.
module tb_act_mac_seq;

  localparam int NUM      = 2;
  localparam int NUM_LSTM = 1;
  localparam int N        = NUM + NUM_LSTM;
  localparam int W        = 32;
  localparam int F        = 24;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic           clk;
  logic           rst;
  logic           i_start;
  logic [N*W-1:0] i_k;
  logic           i_wr;
  logic [N*W-1:0] i_w;
  logic [W-1:0]   i_b;
  logic           o_busy;
  logic           o_act_req;
  logic [W-1:0]   o_act_x;
  logic           i_act_ack;
  logic [W-1:0]   i_act_y;
  logic [W-1:0]   o_a;
  logic           o_valid;
  logic [N*W-1:0] o_w;
  logic [W-1:0]   o_b;

  act_mac_seq #(.NUM(NUM), .NUM_LSTM(NUM_LSTM), .WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_k(i_k), .i_wr(i_wr),
    .i_w(i_w), .i_b(i_b), .o_busy(o_busy), .o_act_req(o_act_req),
    .o_act_x(o_act_x), .i_act_ack(i_act_ack), .i_act_y(i_act_y),
    .o_a(o_a), .o_valid(o_valid), .o_w(o_w), .o_b(o_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int valid_count = 0;

  // Count o_valid pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (o_valid) valid_count++;
  end

  // Reference model: committed and pending weight state
  logic [W-1:0] m_w[N];
  logic [W-1:0] m_b;
  logic [W-1:0] m_pw[N];
  logic [W-1:0] m_pb;
  bit           m_pend;

  typedef struct {
    logic [N*W-1:0] k;
    logic [N*W-1:0] w;
    logic [W-1:0]   b;
    logic [W-1:0]   y;
    logic [W-1:0]   x;
    int             ack_wait;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(input logic [N*W-1:0] k, input logic [N*W-1:0] w,
                              input logic [W-1:0] b, input logic [W-1:0] y,
                              input logic [W-1:0] x, input int ack_wait);
    vec_t v;
    v.k = k; v.w = w; v.b = b; v.y = y; v.x = x; v.ack_wait = ack_wait;
    return v;
  endfunction

  function automatic logic [N*W-1:0] pack_model_w();
    logic [N*W-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = m_w[j];
    return r;
  endfunction

  // Dot product in wide integers, floor-shifted per term, biased, then clamped
  function automatic logic [W-1:0] model_x(input logic [N*W-1:0] k);
    longint acc;
    longint p;
    acc = 0;
    for (int j = 0; j < N; j++) begin
      p = longint'($signed(k[j*W +: W])) * longint'($signed(m_w[j]));
      acc = acc + (p >>> F);
    end
    acc = acc + longint'($signed(m_b));
    if (acc > MAXV) return 32'h7FFF_FFFF;
    if (acc < MINV) return 32'h8000_0000;
    return acc[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_word();
    int r;
    r = int'($urandom);
    r = r >>> $urandom_range(2, 10);
    return W'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_w[j] = '0;
      m_pw[j] = '0;
    end
    m_b = '0;
    m_pb = '0;
    m_pend = 0;
  endtask

  task automatic set_model(input logic [N*W-1:0] w, input logic [W-1:0] b);
    for (int j = 0; j < N; j++) m_w[j] = w[j*W +: W];
    m_b = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_start = 1'b0; i_wr = 1'b0; i_act_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic write_wb(input logic [N*W-1:0] w, input logic [W-1:0] b);
    i_w = w; i_b = b; i_wr = 1'b1;
    tick();
    i_wr = 1'b0;
    set_model(w, b);
  endtask

  // One full operation: start, optional mid-MAC disturbance, handshake, completion.
  // mid: 0 none, 1 extra start pulse during MAC, 2 weight write during MAC.
  task automatic apply_stimulus(input logic [N*W-1:0] k, input int ack_wait,
                                input logic [W-1:0] y, input logic [W-1:0] exp_x,
                                input int mid, input logic [N*W-1:0] mw,
                                input logic [W-1:0] mb, input string tag);
    int  cyc;
    int  early_valid;
    int  busy_drop;
    int  v0;
    bit  seen;
    cyc = 0; early_valid = 0; busy_drop = 0; seen = 0;
    v0 = valid_count;
    i_k = k; i_start = 1'b1; i_act_ack = 1'b0; i_act_y = y;
    while (!seen && cyc < 40) begin
      cyc++;
      if (cyc == 3 && mid == 1) i_start = 1'b1;
      if (cyc == 3 && mid == 2) begin
        i_w = mw; i_b = mb; i_wr = 1'b1;
        for (int j = 0; j < N; j++) m_pw[j] = mw[j*W +: W];
        m_pb = mb;
        m_pend = 1;
      end
      tick();
      i_start = 1'b0;
      i_wr = 1'b0;
      if (cyc == 2) i_k = ~k;
      if (o_valid) early_valid++;
      if (!o_busy) busy_drop++;
      if (o_act_req) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s req_timeout: got no o_act_req, required within %0d cycles", tag, N + 3);
      do_reset();
      return;
    end
    check_output({tag, " req_latency"}, 128'(cyc), 128'(N + 3));
    check_output({tag, " early_valid"}, 128'(early_valid), 128'(0));
    check_output({tag, " busy_before_req"}, 128'(busy_drop), 128'(0));
    check_output({tag, " act_x"}, 128'(o_act_x), 128'(exp_x));
    for (int d = 0; d < ack_wait; d++) begin
      tick();
      check_output({tag, " wait_req"}, 128'(o_act_req), 128'(1'b1));
      check_output({tag, " wait_act_x"}, 128'(o_act_x), 128'(exp_x));
      check_output({tag, " wait_busy"}, 128'(o_busy), 128'(1'b1));
      check_output({tag, " wait_valid"}, 128'(o_valid), 128'(1'b0));
    end
    i_act_ack = 1'b1;
    tick();
    i_act_ack = 1'b0;
    check_output({tag, " valid"}, 128'(o_valid), 128'(1'b1));
    check_output({tag, " o_a"}, 128'(o_a), 128'(y));
    check_output({tag, " req_drop"}, 128'(o_act_req), 128'(1'b0));
    check_output({tag, " busy_done"}, 128'(o_busy), 128'(1'b1));
    check_output({tag, " o_w_done"}, 128'(o_w), 128'(pack_model_w()));
    tick();
    if (m_pend) begin
      for (int j = 0; j < N; j++) m_w[j] = m_pw[j];
      m_b = m_pb;
      m_pend = 0;
    end
    check_output({tag, " valid_drop"}, 128'(o_valid), 128'(1'b0));
    check_output({tag, " idle"}, 128'(o_busy), 128'(1'b0));
    check_output({tag, " o_w_after"}, 128'(o_w), 128'(pack_model_w()));
    check_output({tag, " o_b_after"}, 128'(o_b), 128'(m_b));
    check_output({tag, " valid_pulses"}, 128'(valid_count - v0), 128'(1));
  endtask

  localparam logic [N*W-1:0] K_BASIC = {32'h0080_0000, 32'h0200_0000, 32'h0100_0000};
  localparam logic [N*W-1:0] W_BASIC = {32'hFF00_0000, 32'h0040_0000, 32'h0080_0000};
  localparam logic [W-1:0]   B_BASIC = 32'h0040_0000;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    logic [N*W-1:0] rk;
    logic [N*W-1:0] rw;
    logic [W-1:0]   rb;
    int             idle_busy;
    int             v0;

    rst = 1'b1; i_start = 1'b0; i_wr = 1'b0; i_act_ack = 1'b0;
    i_k = '0; i_w = '0; i_b = '0; i_act_y = '0;
    model_reset();
    #12;
    check_output("reset busy", 128'(o_busy), 128'(1'b0));
    check_output("reset req", 128'(o_act_req), 128'(1'b0));
    check_output("reset valid", 128'(o_valid), 128'(1'b0));
    check_output("reset o_a", 128'(o_a), 128'(0));
    check_output("reset act_x", 128'(o_act_x), 128'(0));
    check_output("reset o_w", 128'(o_w), 128'(0));
    check_output("reset o_b", 128'(o_b), 128'(0));
    tick();
    rst = 1'b0;
    tick();

    tbl[0] = mk(K_BASIC, W_BASIC, B_BASIC, 32'h00A2_95DA, 32'h00C0_0000, 0);
    tbl[1] = mk({3{32'h7F00_0000}}, {3{32'h7F00_0000}}, 32'h0, 32'h00FF_FFFF, 32'h7FFF_FFFF, 0);
    tbl[2] = mk({3{32'h7F00_0000}}, {3{32'h8100_0000}}, 32'h0, 32'hFF00_0001, 32'h8000_0000, 1);
    tbl[3] = mk({32'h0, 32'h0, 32'h0000_0001}, {32'h0, 32'h0, 32'hFFFF_FFFF}, 32'h0,
                32'h1234_5678, 32'hFFFF_FFFF, 0);
    tbl[4] = mk({32'h0, 32'h0, 32'h7F00_0000}, {32'h0, 32'h0, 32'h0100_0000}, 32'h00FF_FFFF,
                32'h0000_0042, 32'h7FFF_FFFF, 2);
    tbl[5] = mk({32'h0, 32'h0, 32'h7F00_0000}, {32'h0, 32'h0, 32'h0100_0000}, 32'h0100_0000,
                32'h0000_0043, 32'h7FFF_FFFF, 0);
    tbl[6] = mk(K_BASIC, W_BASIC, B_BASIC, 32'h0BAD_F00D, 32'h00C0_0000, 5);

    for (int i = 0; i < 7; i++) begin
      write_wb(tbl[i].w, tbl[i].b);
      check_output($sformatf("vec%0d o_w", i), 128'(o_w), 128'(tbl[i].w));
      apply_stimulus(tbl[i].k, tbl[i].ack_wait, tbl[i].y, tbl[i].x, 0, '0, '0,
                     $sformatf("vec%0d", i));
    end

    // Write while busy: old weights used, new ones visible only after DONE
    write_wb(W_BASIC, B_BASIC);
    apply_stimulus(K_BASIC, 0, 32'h0000_1111, 32'h00C0_0000, 2, '0, 32'h0100_0000, "wbusy");
    check_output("wbusy o_w_zero", 128'(o_w), 128'(0));
    apply_stimulus(K_BASIC, 0, 32'h0000_2222, 32'h0100_0000, 0, '0, '0, "wbusy2");

    // Start pulse during MAC must be ignored
    write_wb(W_BASIC, B_BASIC);
    apply_stimulus(K_BASIC, 0, 32'h0000_3333, 32'h00C0_0000, 1, '0, '0, "startmid");
    idle_busy = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_busy || o_act_req) idle_busy++;
    end
    check_output("startmid no_restart", 128'(idle_busy), 128'(0));

    // Simultaneous write and start in IDLE: the new weights are used
    rw = {32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
    i_w = rw; i_b = 32'h0; i_wr = 1'b1;
    set_model(rw, 32'h0);
    apply_stimulus(K_BASIC, 0, 32'h0000_4444, model_x(K_BASIC), 0, '0, '0, "wrstart");
    check_output("wrstart value", 128'(o_act_x), 128'(32'h0380_0000));

    // Reset in the middle of MAC with a write pending
    write_wb(W_BASIC, B_BASIC);
    v0 = valid_count;
    i_k = K_BASIC; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_w = {3{32'h1111_1111}}; i_b = 32'h2222_2222; i_wr = 1'b1;
    tick();
    i_wr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_output("rstmid busy", 128'(o_busy), 128'(1'b0));
    check_output("rstmid req", 128'(o_act_req), 128'(1'b0));
    check_output("rstmid valid", 128'(o_valid), 128'(1'b0));
    check_output("rstmid o_a", 128'(o_a), 128'(0));
    check_output("rstmid o_w", 128'(o_w), 128'(0));
    check_output("rstmid o_b", 128'(o_b), 128'(0));
    check_output("rstmid act_x", 128'(o_act_x), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    idle_busy = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_busy) idle_busy++;
    end
    check_output("rstmid stays_idle", 128'(idle_busy), 128'(0));
    check_output("rstmid no_valid", 128'(valid_count - v0), 128'(0));
    apply_stimulus(K_BASIC, 0, 32'h0000_5555, 32'h0, 0, '0, '0, "postrst");
    check_output("postrst pending_gone", 128'(o_w), 128'(0));

    // Randomized operations against the reference model
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < N; j++) begin
        rk[j*W +: W] = rnd_word();
        rw[j*W +: W] = rnd_word();
      end
      rb = rnd_word();
      write_wb(rw, rb);
      apply_stimulus(rk, int'($urandom_range(0, 3)), $urandom, model_x(rk), 0, '0, '0,
                     $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/act_mac_seq.md
Name: act_mac_seq

Overview:
- Serial controller for one LSTM gate neuron. One multiplier is time-shared across all NUM+NUM_LSTM input/weight pairs, the bias is added, and the sum goes to a shared external tanh/sigmoid unit over a req/ack handshake.
- Holds the neuron's weight/bias register and sits between the LSTM cell sequencer and the activation unit.
- Replaces the fully parallel multiplier bank with an N-cycle sequenced datapath.

Parameters:
- NUM, 68: external input count.
- NUM_LSTM, 8: recurrent input count. N = NUM+NUM_LSTM.
- WIDTH, 32: signed fixed-point word width.
- FRAC, 24: fractional bits (Q8.24; 1.0 = 0x01000000).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_start  in  1  start request, one-cycle pulse, honoured only in IDLE.
- i_k  in  N*WIDTH  input vector; element j at [j*WIDTH +: WIDTH].
- i_wr  in  1  weight/bias write strobe.
- i_w  in  N*WIDTH  new weights (same packing as i_k).
- i_b  in  WIDTH  new bias.
- o_busy  out  1  high in any state other than IDLE.
- o_act_req  out  1  activation request.
- o_act_x  out  WIDTH  saturated pre-activation sum to the activation unit.
- i_act_ack  in  1  activation unit accept/result-valid.
- i_act_y  in  WIDTH  activation result.
- o_a  out  WIDTH  registered activation output.
- o_valid  out  1  one-cycle pulse: o_a updated.
- o_w  out  N*WIDTH  current weight register.
- o_b  out  WIDTH  current bias register.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - Weights, bias, accumulator, index, pending-write flag, o_a and o_act_x are all cleared to 0.
  - o_busy, o_act_req and o_valid go to 0.
  - A reset mid-operation aborts the operation with no o_valid.
- States: IDLE -> LOAD -> MAC -> BIAS -> ACT -> DONE -> IDLE.
- IDLE:
  - i_start=1 moves to LOAD.
  - i_wr=1 writes {i_w, i_b} at this edge.
  - If i_wr and i_start arrive together, the write lands first and the computation uses the new weights.
- LOAD (1 cycle): latch i_k into an internal shift buffer, clear the accumulator, set index to 0.
- MAC (exactly N cycles), one term per cycle:
  - p = k[idx] * w[idx], full 2*WIDTH signed product.
  - The term is p >>> FRAC, an arithmetic shift truncating toward -inf.
  - The term is sign-extended into a 2*WIDTH accumulator. The accumulator does not saturate internally.
  - After idx = N-1, go to BIAS.
- BIAS (1 cycle):
  - Add the sign-extended bias to the accumulator.
  - Saturate the result to WIDTH: above 0x7FFFFFFF gives 0x7FFFFFFF, below 0x80000000 gives 0x80000000.
  - Register the result into o_act_x.
- ACT:
  - o_act_req=1 and o_act_x is held stable until an edge samples i_act_ack=1.
  - At that edge, latch i_act_y into o_a, drop o_act_req and go to DONE.
  - There is no timeout.
- DONE (1 cycle): o_valid=1, then return to IDLE.
- Latency:
  - With start sampled at edge t, o_act_req goes high after edge t+N+2.
  - With ack sampled at edge a, o_valid is high during the cycle after edge a.
  - With zero-wait ack, o_valid rises N+4 cycles after start.
- Start while busy: ignored, with no queueing.
- i_wr while busy:
  - Data is captured into a one-deep pending buffer. A later i_wr overwrites it (last write wins).
  - The pending write is applied at the DONE->IDLE edge.
  - The in-flight computation always uses the old weights.
  - On reset the pending write is discarded.
- o_w and o_b always show the committed weight register, never the pending buffer.
- i_k changes after LOAD do not affect the running computation.

Test Plan (all scenarios use NUM=2, NUM_LSTM=1, so N=3, unless stated):
- Basic dot product:
  - Stimulus: write w={0x00800000, 0x00400000, 0xFF000000} (0.5, 0.25, -1.0), b=0x00400000; start with k={0x01000000, 0x02000000, 0x00800000}.
  - Response: o_act_x=0x00C00000 (0.75). Ack in the same cycle with i_act_y=0x00A295DA gives o_valid exactly 7 cycles after start and o_a=0x00A295DA.
- Saturation:
  - Stimulus: all k and w = 0x7F000000, b=0.
  - Response: o_act_x=0x7FFFFFFF. With w=0x81000000 (-127.0), o_act_x=0x80000000.
- Delayed ack:
  - Stimulus: hold i_act_ack=0 for 5 cycles in ACT.
  - Response: o_act_req stays 1 and o_act_x is unchanged. o_valid comes 1 cycle after the ack edge, and o_busy stays high throughout.
- Write during busy:
  - Stimulus: i_wr mid-MAC with w all 0, b=0x01000000.
  - Response: the current result uses the old weights and o_w is unchanged until DONE. A second start then yields o_act_x=0x01000000.
- Start collisions:
  - Stimulus: i_start pulsed during MAC.
  - Response: ignored, with only one o_valid. Simultaneous i_wr+i_start in IDLE computes with the new weights.
- Reset mid-MAC:
  - Stimulus: assert rst at idx=1.
  - Response: immediately o_busy=0, o_act_req=0, o_a=0, o_w=0, o_b=0, with no o_valid pulse and no pending write surviving.
